// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, FSM states, address geometry.
// Latency: none (constants and types only).
// Backpressure: none.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam int ROW_W = 13;
  localparam int COL_W = 9;
  localparam int BURST = 4;

  // Last burst-aligned column of a row; finishing it moves to the next row.
  localparam logic [COL_W-1:0] COL_LAST = 9'd508;

  // A10 high during PRECHARGE selects all banks.
  localparam logic [ROW_W-1:0] ADDR_PRE_ALL = 13'h0400;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACT  = 3'd2,
    S_WR   = 3'd3,
    S_PRE  = 3'd4,
    S_END  = 3'd5
  } sdram_state_t;

endpackage

// File: rtl/sdram_write.sv
// SDRAM write engine: ACT, back-to-back BL4 WRITEs fed from a FIFO, then PRECHARGE-all.
// Latency: ACT one cycle after grant, first WRITE TRCD later, end pulse TWR+TRP after last data.
// Backpressure: waits on wr_en grant; stops between bursts on ref_req, low FIFO level or row end.
module sdram_write
  import sdram_pkg::*;
#(
  parameter int TRCD = 2,
  parameter int TWR  = 2,
  parameter int TRP  = 2
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic             wr_trig,
  input  logic             wr_en,
  output logic             wr_req,
  output logic             flag_wr_end,
  input  logic             ref_req,
  output logic [3:0]       wr_cmd,
  output logic [ROW_W-1:0] wr_addr,
  output logic [1:0]       bank_addr,
  output logic [15:0]      wr_data,
  output logic             wfifo_rd_en,
  input  logic [15:0]      wfifo_rd_data,
  input  logic [9:0]       wfifo_cnt
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] ACT_LAST   = CNT_W'(TRCD - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);
  localparam logic [CNT_W-1:0] DECIDE_AT  = CNT_W'(BURST - 2);
  localparam logic [CNT_W-1:0] PRE_AT     = CNT_W'(TWR - 1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(TWR + TRP - 2);
  localparam logic [9:0]       LVL_START  = 10'd4;
  localparam logic [9:0]       LVL_CONT   = 10'd5;

  sdram_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             cont_q, cont_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  // Data goes straight from the FIFO read port to DQ; pops are issued one cycle early.
  assign wr_data   = wfifo_rd_data;
  assign bank_addr = 2'b00;

  // Next-state and command decode; outputs depend on registered state only.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    cont_d      = cont_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_cmd      = CMD_NOP;
    wr_addr     = '0;
    wfifo_rd_en = 1'b0;
    wr_req      = 1'b0;
    flag_wr_end = 1'b0;

    // Triggers only count before the grant, and only if a full burst is buffered.
    if ((state_q == S_IDLE || state_q == S_REQ) && wr_trig && wfifo_cnt >= LVL_START) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_REQ;
      end
      S_REQ: begin
        wr_req = 1'b1;
        if (wr_en) begin
          state_d = S_ACT;
          cnt_d   = '0;
        end
      end
      S_ACT: begin
        if (cnt_q == '0) begin
          wr_cmd  = CMD_ACT;
          wr_addr = row_q;
        end
        if (cnt_q == ACT_LAST) begin
          wfifo_rd_en = 1'b1;
          state_d     = S_WR;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        // The last pop slot of a burst is the first pop of the next one, if any.
        wfifo_rd_en = (cnt_q != BURST_LAST) || cont_q;
        if (cnt_q == '0) begin
          wr_cmd  = CMD_WR;
          wr_addr = {4'b0000, col_q};
        end
        if (cnt_q == DECIDE_AT) begin
          cont_d = !ref_req && (wfifo_cnt >= LVL_CONT) && (col_q != COL_LAST);
        end
        if (cnt_q == BURST_LAST) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + COL_W'(BURST);
          end
          cnt_d = '0;
          if (!cont_q) state_d = S_PRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == PRE_AT) begin
          wr_cmd  = CMD_PRE;
          wr_addr = ADDR_PRE_ALL;
        end
        if (cnt_q == PRE_LAST) begin
          state_d = S_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_END: begin
        flag_wr_end = 1'b1;
        // Leftover data keeps the request alive, e.g. after a refresh interruption.
        pend_d      = (wfifo_cnt >= LVL_START);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, timing counter and address bookkeeping registers.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      cont_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      cont_q  <= cont_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// Bench for sdram_write: FIFO model plus a session-level reference built from burst arithmetic.
// Latency: n/a.
// Backpressure: grant delay and post-grant wr_en toggling are randomized.
module tb_sdram_write;

  localparam int TRCD = 2;
  localparam int TWR  = 2;
  localparam int TRP  = 2;
  localparam int NEVER = 1000000;
  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRT = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  logic        sclk = 1'b0;
  logic        s_rst_n = 1'b0;
  logic        wr_trig = 1'b0;
  logic        wr_en = 1'b0;
  logic        ref_req = 1'b0;
  logic        wr_req, flag_wr_end, wfifo_rd_en;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  bank_addr;
  logic [15:0] wr_data;
  logic [15:0] wfifo_rd_data = 16'h0000;
  logic [9:0]  wfifo_cnt;

  always #5 sclk = ~sclk;

  sdram_write #(.TRCD(TRCD), .TWR(TWR), .TRP(TRP)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .wr_trig(wr_trig), .wr_en(wr_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .ref_req(ref_req),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .bank_addr(bank_addr), .wr_data(wr_data),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_rd_data(wfifo_rd_data), .wfifo_cnt(wfifo_cnt)
  );

  // Write-FIFO model: data valid the cycle after a pop, count excludes the current pop.
  logic [15:0] mem [0:1023];
  int wp = 0;
  int rp = 0;
  assign wfifo_cnt = 10'(wp - rp);
  always @(posedge sclk) begin
    if (wfifo_rd_en) begin
      wfifo_rd_data <= mem[10'(rp)];
      rp <= rp + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int m_row = 0;
  int m_col = 0;
  int m_base = 0;
  int obs_wr, obs_pops;

  logic [3:0]  e_cmd  [0:2047];
  logic [12:0] e_addr [0:2047];
  logic        e_rd   [0:2047];
  logic        e_dv   [0:2047];
  logic [15:0] e_dat  [0:2047];

  task automatic push_word(input logic [15:0] w);
    mem[10'(wp)] = w;
    wp++;
  endtask

  task automatic fill_to(input int n);
    while (wp - m_base < n) push_word(16'($urandom));
  endtask

  task automatic pulse_trig();
    @(negedge sclk); wr_trig = 1'b1;
    @(negedge sclk); wr_trig = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sclk);
    s_rst_n = 1'b0; wr_en = 1'b0; wr_trig = 1'b0; ref_req = 1'b0;
    repeat (2) @(negedge sclk);
    s_rst_n = 1'b1;
    m_row = 0; m_col = 0; m_base = rp;
  endtask

  // One granted session: expected trace from burst arithmetic, then cycle-by-cycle compare.
  // ref_on is the session cycle (0 = ACT) from which ref_req is held high.
  task automatic run_session(input int ref_on);
    int c0, t, nb, e_end, d, row, col, cnt_at;
    bit cont, seen, exp_pend;
    obs_wr = 0; obs_pops = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge sclk);
      if (wr_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL req_timeout: wr_req=%b required 1 within 60 cycles", wr_req);
      return;
    end
    d = $urandom_range(0, 2);
    for (int i = 0; i < d; i++) begin
      @(negedge sclk);
      checks++;
      if (wr_req !== 1'b1) begin
        errors++;
        $display("FAIL req_hold: wr_req=%b required 1 while ungranted", wr_req);
      end
    end
    wr_en = 1'b1;

    for (int o = 0; o < 2048; o++) begin
      e_cmd[o] = NOP; e_addr[o] = '0; e_rd[o] = 1'b0; e_dv[o] = 1'b0; e_dat[o] = '0;
    end
    c0 = wp - m_base; row = m_row; col = m_col; nb = 0;
    e_cmd[0] = ACT; e_addr[0] = 13'(row);
    t = TRCD; cont = 1'b1;
    while (cont) begin
      e_cmd[t] = WRT; e_addr[t] = 13'(col);
      for (int i = 0; i < 4; i++) begin
        e_rd[t-1+i] = 1'b1;
        e_dv[t+i]   = 1'b1;
        e_dat[t+i]  = mem[10'(m_base + 4*nb + i)];
      end
      cnt_at = c0 - (4*nb + 3);
      cont = (ref_on > t + 2) && (cnt_at >= 5) && (col != 508);
      if (col == 508) begin col = 0; row = (row + 1) % 8192; end
      else col = col + 4;
      nb++;
      if (cont) t = t + 4;
    end
    e_cmd[t+3+TWR] = PRE; e_addr[t+3+TWR] = 13'h0400;
    e_end = t + 3 + TWR + TRP;
    exp_pend = (c0 - 4*nb) >= 4;

    for (int o = 0; o <= e_end + 1; o++) begin
      @(negedge sclk);
      if (wr_cmd === WRT) obs_wr++;
      if (wfifo_rd_en === 1'b1) obs_pops++;
      checks++;
      if (wr_cmd !== e_cmd[o]) begin
        errors++;
        $display("FAIL cmd[%0d]: got %b required %b", o, wr_cmd, e_cmd[o]);
      end
      if (e_cmd[o] != NOP) begin
        checks++;
        if (wr_addr !== e_addr[o] || bank_addr !== 2'b00) begin
          errors++;
          $display("FAIL addr[%0d]: got %h/%b required %h/00", o, wr_addr, bank_addr, e_addr[o]);
        end
      end
      checks++;
      if (wfifo_rd_en !== e_rd[o]) begin
        errors++;
        $display("FAIL rd_en[%0d]: got %b required %b", o, wfifo_rd_en, e_rd[o]);
      end
      if (e_dv[o]) begin
        checks++;
        if (wr_data !== e_dat[o]) begin
          errors++;
          $display("FAIL data[%0d]: got %h required %h", o, wr_data, e_dat[o]);
        end
      end
      checks++;
      if (flag_wr_end !== (o == e_end)) begin
        errors++;
        $display("FAIL flag[%0d]: got %b required %b", o, flag_wr_end, (o == e_end));
      end
      checks++;
      if (wr_req !== 1'b0) begin
        errors++;
        $display("FAIL req_in_session[%0d]: got %b required 0", o, wr_req);
      end
      ref_req = (o >= ref_on) && (o < e_end);
      wr_en   = (o < e_end) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    ref_req = 1'b0; wr_en = 1'b0;
    @(negedge sclk);
    checks++;
    if (wr_req !== exp_pend) begin
      errors++;
      $display("FAIL re_request: wr_req=%b required %b", wr_req, exp_pend);
    end
    m_row = row; m_col = col; m_base = m_base + 4*nb;
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    checks++;
    if (wr_cmd !== NOP || wr_addr !== 13'd0 || bank_addr !== 2'b00) begin
      errors++;
      $display("FAIL reset_cmd: got %b/%h/%b required %b/0000/00", wr_cmd, wr_addr, bank_addr, NOP);
    end
    checks++;
    if (wr_req !== 1'b0 || flag_wr_end !== 1'b0 || wfifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: req=%b flag=%b rd=%b required 0 0 0", wr_req, flag_wr_end, wfifo_rd_en);
    end
    checks++;
    if (wr_data !== wfifo_rd_data) begin
      errors++;
      $display("FAIL reset_data: got %h required %h", wr_data, wfifo_rd_data);
    end
    s_rst_n = 1'b1;
    m_row = 0; m_col = 0; m_base = rp;
  endtask

  task automatic test_single_burst();
    push_word(16'h0f10); push_word(16'h0f55); push_word(16'h0faa); push_word(16'h0f01);
    pulse_trig();
    run_session(NEVER);
    checks++;
    if (obs_wr != 1 || obs_pops != 4) begin
      errors++;
      $display("FAIL single_counts: writes=%0d pops=%0d required 1 4", obs_wr, obs_pops);
    end
  endtask

  task automatic test_fifo_gating();
    push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
    pulse_trig();
    for (int i = 0; i < 20; i++) begin
      @(negedge sclk);
      checks++;
      if (wr_req !== 1'b0 || wr_cmd !== NOP) begin
        errors++;
        $display("FAIL gating[%0d]: req=%b cmd=%b required 0 %b", i, wr_req, wr_cmd, NOP);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fill_to(12);
    pulse_trig();
    run_session(NEVER);
    checks++;
    if (obs_wr != 3 || obs_pops != 12) begin
      errors++;
      $display("FAIL b2b_counts: writes=%0d pops=%0d required 3 12", obs_wr, obs_pops);
    end
  endtask

  task automatic test_refresh_stop();
    // Refresh before t+2 of burst 1, exactly at t+2, and just after it.
    fill_to(12); pulse_trig();
    run_session(TRCD + 1);
    run_session(NEVER);
    fill_to(12); pulse_trig();
    run_session(TRCD + 2);
    run_session(NEVER);
    fill_to(12); pulse_trig();
    run_session(TRCD + 3);
    checks++;
    if (obs_wr != 2) begin
      errors++;
      $display("FAIL refresh_late: writes=%0d required 2", obs_wr);
    end
    run_session(NEVER);
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    fill_to(8); pulse_trig();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge sclk);
      if (wr_req === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_req_timeout: wr_req=%b required 1", wr_req);
    end
    wr_en = 1'b1;
    for (int o = 0; o <= TRCD + 2; o++) @(negedge sclk);
    s_rst_n = 1'b0; wr_en = 1'b0;
    @(negedge sclk);
    checks++;
    if (wr_cmd !== NOP || wfifo_rd_en !== 1'b0 || wr_req !== 1'b0 || flag_wr_end !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: cmd=%b rd=%b req=%b flag=%b required %b 0 0 0",
               wr_cmd, wfifo_rd_en, wr_req, flag_wr_end, NOP);
    end
    s_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sclk);
      checks++;
      if (wr_req !== 1'b0 || wr_cmd !== NOP) begin
        errors++;
        $display("FAIL rst_idle[%0d]: req=%b cmd=%b required 0 %b", i, wr_req, wr_cmd, NOP);
      end
    end
    m_row = 0; m_col = 0; m_base = rp;
  endtask

  task automatic test_row_wrap();
    do_reset();
    while (m_row < 5) begin
      fill_to(512 - m_col);
      pulse_trig();
      run_session(NEVER);
    end
    fill_to(508); pulse_trig();
    run_session(NEVER);
    fill_to(8); pulse_trig();
    run_session(NEVER);
    checks++;
    if (obs_wr != 1) begin
      errors++;
      $display("FAIL wrap_single: writes=%0d required 1", obs_wr);
    end
    run_session(NEVER);
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 12; it++) begin
      fill_to((wp - m_base) + $urandom_range(0, 30));
      if (wp - m_base >= 4) begin
        pulse_trig();
        r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : NEVER;
        run_session(r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_fifo_gating();
    test_back_to_back();
    test_refresh_stop();
    test_reset_mid_burst();
    test_row_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_write.md
SDRAM_WRITE -- requirements
Module: sdram_write

Interface
REQ-001 SHALL have parameters: TRCD, default 2, ACT-to-WRITE cycles; TWR, default 2, last-data-to-PRECHARGE cycles; TRP, default 2, PRECHARGE-to-end cycles.
REQ-002 SHALL have ports (name, direction, width, meaning):
- sclk, in, 1, the single clock.
- s_rst_n, in, 1, reset: synchronous, active-low.
- wr_trig, in, 1, pulse requesting a write session.
- wr_en, in, 1, arbiter grant.
- wr_req, out, 1, request to arbiter.
- flag_wr_end, out, 1, one-cycle session-done pulse.
- ref_req, in, 1, refresh pending.
- wr_cmd, out, 4, {cs_n, ras_n, cas_n, we_n}.
- wr_addr, out, 13, SDRAM address.
- bank_addr, out, 2, SDRAM bank.
- wr_data, out, 16, SDRAM DQ data.
- wfifo_rd_en, out, 1, write-FIFO pop.
- wfifo_rd_data, in, 16, FIFO data, valid 1 cycle after pop.
- wfifo_cnt, in, 10, FIFO occupancy, excluding the current-cycle pop.

Function
REQ-003 SHALL encode commands as NOP=4'b0111, ACT=4'b0011, WRITE=4'b0100, PRE=4'b0010, and drive NOP in every cycle not specified below.
REQ-004 SHALL implement the FSM: S_IDLE -> S_REQ -> S_ACT -> S_WR -> S_PRE -> S_END -> S_IDLE.
REQ-005 SHALL accept wr_trig only when wfifo_cnt>=4, setting a pending flag; a rejected wr_trig SHALL be dropped.
REQ-006 In S_IDLE with the pending flag set, SHALL move to S_REQ and hold wr_req=1 until the first cycle wr_en=1.
REQ-007 SHALL issue ACT on the cycle after the grant (cycle A), with wr_addr=row and bank_addr=2'b00.
REQ-008 SHALL issue the first WRITE at cycle A+TRCD, with wr_addr={4'b0000, col[8:0]}, A10=0 (no auto-precharge), and burst length 4.
REQ-009 For a WRITE issued at cycle t, SHALL assert wfifo_rd_en on cycles t-1..t+2; wr_data SHALL equal wfifo_rd_data combinationally, so words 0..3 appear on cycles t..t+3.
REQ-010 SHALL decide at cycle t+2 whether to continue: continue iff ref_req==0, wfifo_cnt>=5, and col!=508. On continue, SHALL issue the next WRITE at t+4 with no gap.
REQ-011 SHALL advance col by 4 after each burst; when col=508 completes, col SHALL wrap to 0 and row SHALL increment (8191 wraps to 0); a row change always ends the session.
REQ-012 On stop, SHALL issue PRE at t+3+TWR with wr_addr[10]=1 (all banks), and pulse flag_wr_end exactly TRP cycles after PRE.
REQ-013 SHALL return to S_IDLE the cycle after flag_wr_end.
REQ-014 SHALL clear the pending flag at flag_wr_end if wfifo_cnt<4 at that point, otherwise keep it set, so a session stopped by ref_req re-requests automatically.
REQ-015 Between grant and flag_wr_end, SHALL ignore wr_en deassertion and new wr_trig.
REQ-016 ref_req asserted before cycle t+2 of the last allowed burst SHALL NOT truncate a burst in progress.
REQ-017 wr_req SHALL be 0 outside S_REQ; flag_wr_end SHALL be 0 outside S_END.

Reset
REQ-018 On s_rst_n=0 at a sclk edge, SHALL set state=S_IDLE, pending=0, row=0, col=0, wr_cmd=NOP, wr_addr=0, bank_addr=0, wr_req=0, flag_wr_end=0, and wfifo_rd_en=0; wr_data follows wfifo_rd_data.
REQ-019 Reset asserted mid-session SHALL abort immediately, with no PRE issued; the arbiter/init block re-precharges afterwards.

Structure
REQ-020 SHALL take command encodings, state encodings, and address widths (ROW_W=13, COL_W=9, BURST=4) from the shared sdram_pkg, which sdram_read also uses.
REQ-021 SHALL be a single module with no sub-modules; the timing counter is inline.

Verification
REQ-022 Single burst: wfifo_cnt=4, wr_trig, grant -> ACT row 0; WRITE col 0 two cycles later; data 16'h0f10, 16'h0f55, 16'h0faa, 16'h0f01 on four consecutive cycles; PRE at last+2; flag_wr_end two cycles after PRE.
REQ-023 Back-to-back: wfifo_cnt=12 -> three WRITEs at cols 0, 4, 8, spaced exactly 4 cycles apart; 12 pops; one PRE.
REQ-024 Refresh stop: wfifo_cnt=12, ref_req raised during burst 1 before its cycle t+2 -> burst 1 completes, then PRE and flag_wr_end; pending stays 1; wr_req re-asserts once ref_req clears and the grant is removed.
REQ-025 FIFO gating: wfifo_cnt=3 plus wr_trig -> wr_req never asserts; wr_cmd stays NOP.
REQ-026 Row wrap: col preset 508, row 5, wfifo_cnt=8 -> one burst at col 508, PRE, end; next session ACT on row 6 at col 0.
REQ-027 Reset mid-burst: s_rst_n=0 during word 2 -> next cycle wr_cmd=NOP, wfifo_rd_en=0, wr_req=0, state S_IDLE.
